// File: rtl/gck_hyst_ctrl.sv
// Multi-channel hysteretic clock gate.
// Each channel runs a small OFF/WAKE/ON/HOLD handshake controller whose
// "clock wanted" term, ORed with the test/force overrides, feeds a
// negative-level enable latch. The latch output is ANDed with CP, so Q
// can only change while CP is low and never produces a runt pulse.

module gck_hyst_lane #(
    parameter int CW       = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic          CP,
    input  logic          CDN,
    input  logic          te,
    input  logic          req,
    input  logic          force_on,
    input  logic [CW-1:0] hold_cyc,
    output logic          ack,
    output logic          q,
    output logic          en_stat
);

    typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} state_t;

    localparam logic [CW-1:0] WAKE_INIT = CW'(WAKE_CYC - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ovr, en_d, lat;

    // Next-state and counter: counters load on entry, count down, never wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            OFF: begin
                if (req) begin
                    state_n = WAKE;
                    cnt_n   = WAKE_INIT;
                end
            end
            WAKE: begin
                if (!req) begin
                    state_n = HOLD;
                    cnt_n   = hold_cyc;
                end else if (cnt == '0) begin
                    state_n = ON;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ON: begin
                if (!req) begin
                    state_n = HOLD;
                    cnt_n   = hold_cyc;
                end
            end
            HOLD: begin
                // Clock never stopped in HOLD, so a new request skips WAKE.
                if (req) begin
                    state_n = ON;
                end else if (cnt == '0) begin
                    state_n = OFF;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: state_n = OFF;
        endcase
    end

    // State, counter and registered ack (high exactly while in ON).
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state <= OFF;
            cnt   <= '0;
            ack   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ack   <= (state_n == ON);
        end
    end

    assign ovr  = te | force_on;
    assign en_d = (state != OFF) | ovr;

    // Enable latch: transparent while CP is low; reset clears it at once
    // unless an override is holding the clock on.
    always_latch begin
        if (!CDN && !ovr)
            lat = 1'b0;
        else if (!CP)
            lat = en_d;
    end

    assign q       = CP & lat;
    assign en_stat = lat;

endmodule

module gck_hyst_ctrl #(
    parameter int NCH      = 4,
    parameter int CW       = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic           CP,
    input  logic           CDN,
    input  logic           TE,
    input  logic [NCH-1:0] REQ,
    input  logic [NCH-1:0] FORCE_ON,
    input  logic [CW-1:0]  HOLD_CYC,
    output logic [NCH-1:0] ACK,
    output logic [NCH-1:0] Q,
    output logic [NCH-1:0] EN_STAT
);

    gck_hyst_lane #(
        .CW       (CW),
        .WAKE_CYC (WAKE_CYC)
    ) u_lane [NCH-1:0] (
        .CP       (CP),
        .CDN      (CDN),
        .te       (TE),
        .req      (REQ),
        .force_on (FORCE_ON),
        .hold_cyc (HOLD_CYC),
        .ack      (ACK),
        .q        (Q),
        .en_stat  (EN_STAT)
    );

endmodule

// File: tb/tb_gck_hyst_ctrl.sv
// Directed bench for gck_hyst_ctrl (NCH=4, CW=8, WAKE_CYC=2).
// Outputs are sampled 1 time unit after each rising edge, so Q shows
// whether that edge was passed through the gate.

module tb_gck_hyst_ctrl;

    logic       CP;
    logic       CDN;
    logic       TE;
    logic [3:0] REQ;
    logic [3:0] FORCE_ON;
    logic [7:0] HOLD_CYC;
    logic [3:0] ACK;
    logic [3:0] Q;
    logic [3:0] EN_STAT;

    int nerr = 0;
    int nchk = 0;

    gck_hyst_ctrl #(.NCH(4), .CW(8), .WAKE_CYC(2)) dut (
        .CP       (CP),
        .CDN      (CDN),
        .TE       (TE),
        .REQ      (REQ),
        .FORCE_ON (FORCE_ON),
        .HOLD_CYC (HOLD_CYC),
        .ACK      (ACK),
        .Q        (Q),
        .EN_STAT  (EN_STAT)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        CDN = 1'b0; TE = 1'b0; REQ = 4'h0; FORCE_ON = 4'h0; HOLD_CYC = 8'd3;

        // Reset hold: everything quiet.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rst_q", Q, 4'h0);
            chk("rst_ack", ACK, 4'h0);
            chk("rst_en", EN_STAT, 4'h0);
        end
        @(negedge CP); #1 CDN = 1'b1;

        // Channel 0 wake: REQ sampled at edge A, pulse at A+1, ACK after A+2.
        REQ = 4'b0001;
        tick(); chk("w0_a_q", Q, 4'b0000); chk("w0_a_ack", ACK, 4'b0000);
        tick(); chk("w0_a1_q", Q, 4'b0001); chk("w0_a1_ack", ACK, 4'b0000);
        chk("w0_a1_en", EN_STAT, 4'b0001);
        tick(); chk("w0_a2_q", Q, 4'b0001); chk("w0_a2_ack", ACK, 4'b0001);

        // Channel 1 hysteresis with HOLD_CYC=3; change mid-HOLD is ignored.
        REQ = 4'b0011;
        tick(); tick(); tick();
        chk("c1_on_ack", ACK, 4'b0011);
        REQ = 4'b0001;
        tick(); chk("c1_hold_ack", ACK, 4'b0001); chk("c1_hold_q", Q, 4'b0011);
        HOLD_CYC = 8'd0;
        for (int k = 1; k <= 4; k++) begin
            tick(); chk($sformatf("c1_hold%0d_q", k), Q, 4'b0011);
        end
        tick(); chk("c1_off_q", Q, 4'b0001);
        tick(); chk("c1_off2_q", Q, 4'b0001);

        // Channel 2 re-request from HOLD at cnt=1: straight to ON, no gap.
        HOLD_CYC = 8'd3;
        REQ = 4'b0101;
        tick(); tick(); tick();
        chk("c2_on_ack", ACK, 4'b0101);
        REQ = 4'b0001;
        tick(); chk("c2_h3_ack", ACK, 4'b0001); chk("c2_h3_q", Q, 4'b0101);
        tick(); chk("c2_h2_q", Q, 4'b0101);
        tick(); chk("c2_h1_q", Q, 4'b0101);
        REQ = 4'b0101;
        tick(); chk("c2_reon_ack", ACK, 4'b0101); chk("c2_reon_q", Q, 4'b0101);

        // HOLD_CYC=0: single HOLD cycle.
        HOLD_CYC = 8'd0;
        REQ = 4'b0001;
        tick(); chk("c2_h0_ack", ACK, 4'b0001); chk("c2_h0_q", Q, 4'b0101);
        tick(); chk("c2_h0_last_q", Q, 4'b0101);
        tick(); chk("c2_h0_off_q", Q, 4'b0001);

        // REQ drop during WAKE goes to HOLD; ACK never rises.
        REQ = 4'b0101;
        tick(); chk("c2_wk_q", Q, 4'b0001); chk("c2_wk_ack", ACK, 4'b0001);
        REQ = 4'b0001;
        tick(); chk("c2_wh_q", Q, 4'b0101); chk("c2_wh_ack", ACK, 4'b0001);
        tick(); chk("c2_wo_q", Q, 4'b0101); chk("c2_wo_ack", ACK, 4'b0001);
        tick(); chk("c2_wx_q", Q, 4'b0001); chk("c2_wx_ack", ACK, 4'b0001);

        // Drain channel 0.
        REQ = 4'b0000;
        tick(); chk("c0_dr_ack", ACK, 4'b0000);
        tick();
        tick(); chk("c0_dr_q", Q, 4'b0000); chk("c0_dr_en", EN_STAT, 4'b0000);

        // TE asserted mid high phase: no runt, clock from next full high phase.
        tick();
        #2 TE = 1'b1;
        #1 chk("te_on_hi_q", Q, 4'h0);
        @(negedge CP); #1;
        chk("te_lo_en", EN_STAT, 4'hf); chk("te_lo_q", Q, 4'h0);
        tick(); chk("te_q", Q, 4'hf); chk("te_ack", ACK, 4'h0);
        tick(); chk("te_q2", Q, 4'hf);
        #2 TE = 1'b0;
        #1 chk("te_off_hi_q", Q, 4'hf);
        @(negedge CP); #1;
        chk("te_off_en", EN_STAT, 4'h0); chk("te_off_lo_q", Q, 4'h0);
        tick(); chk("te_off_q", Q, 4'h0); chk("te_off_ack", ACK, 4'h0);

        // FORCE_ON[3], then handshake takes over with no interruption.
        FORCE_ON = 4'b1000;
        tick(); chk("f3_q", Q, 4'b1000); chk("f3_ack", ACK, 4'b0000);
        tick(); chk("f3_q2", Q, 4'b1000);
        REQ = 4'b1000;
        tick(); chk("f3_wk_q", Q, 4'b1000); chk("f3_wk_ack", ACK, 4'b0000);
        FORCE_ON = 4'b0000;
        tick(); chk("f3_rel_q", Q, 4'b1000); chk("f3_rel_ack", ACK, 4'b0000);
        tick(); chk("f3_on_q", Q, 4'b1000); chk("f3_on_ack", ACK, 4'b1000);
        REQ = 4'b0000;
        tick(); chk("f3_h_ack", ACK, 4'b0000);
        tick();
        tick(); chk("f3_off_q", Q, 4'b0000);

        // Reset mid-WAKE (ch0) and mid-HOLD (ch1) while CP is high.
        HOLD_CYC = 8'd5;
        REQ = 4'b0010;
        tick(); tick(); tick();
        chk("r_c1_on", ACK, 4'b0010);
        REQ = 4'b0001;
        tick();
        tick(); chk("r_pre_q", Q, 4'b0011);
        #1 CDN = 1'b0;
        #1;
        chk("r_q", Q, 4'b0000); chk("r_en", EN_STAT, 4'b0000); chk("r_ack", ACK, 4'b0000);
        @(negedge CP); #1 CDN = 1'b1;
        tick(); chk("r_e0_q", Q, 4'b0000); chk("r_e0_ack", ACK, 4'b0000);
        tick(); chk("r_e1_q", Q, 4'b0001); chk("r_e1_ack", ACK, 4'b0000);
        tick(); chk("r_e2_q", Q, 4'b0001); chk("r_e2_ack", ACK, 4'b0001);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
